// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared MIPS front-end constants and default datapath widths
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 32;

    // All-zero word is sll $0,$0,0, i.e. the canonical MIPS NOP.
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================================
// inst_queue : fetch-to-decode instruction FIFO with PC tags and flush
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_queue
    import mips_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEPTH  = 4            // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_W-1:0]          out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               push;
    logic               pop;

    // Flush gates in_ready, so a push can never coincide with a flush edge.
    assign in_ready  = (cnt < CNT_W'(DEPTH)) && !flush;
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = cnt;

    // Empty slots may hold stale data; mask to NOP/0 when nothing is valid.
    assign out_inst = out_valid ? mem[rd_ptr].inst : INST_W'(INST_NOP);
    assign out_pc   = out_valid ? mem[rd_ptr].pc   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
        end
    end

endmodule

`default_nettype wire
